uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver: one block replaces the rx_control/bps/H2L-detect trio.
//  Contains an input synchroniser, falling-edge detection and the baud counter.
//  Data width, parity and stop-bit count are configurable.
//  Bits are sampled mid-bit with a 3-sample majority vote; parity and framing errors are flagged.
//  Sits between the FPGA RX pin and the user FIFO/consumer.
// PARAMETERS
//  CLKS_PER_BIT  434  CLK cycles per bit (50 MHz / 115200); legal range 8..65535
//  DATA_BITS     8    data bits per frame, 5..9, sent LSB first
//  PARITY        0    0 = none, 1 = odd, 2 = even
//  STOP_BITS     1    1 or 2
// PORTS
//  CLK          in   1          system clock
//  RST_n        in   1          asynchronous, active-low reset
//  Rx_Pin_In    in   1          raw serial line; idle high; asynchronous to CLK
//  Rx_En_Sig    in   1          receive enable; low = ignore line / abort frame
//  Rx_Data      out  DATA_BITS  last received word; held until the next Done
//  Rx_Done_Sig  out  1          1-cycle pulse: frame complete, Rx_Data/err valid
//  Parity_Err   out  1          parity mismatch on the last frame (0 if PARITY=0)
//  Frame_Err    out  1          a stop-bit sample was low on the last frame
//  Busy         out  1          high from start-edge detect until return to IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; synchroniser flops preset to 1 (line idle).
//  Synchroniser: 2 FFs on Rx_Pin_In -> rx_s. Edge detect compares rx_s with a 3rd FF.
//  Baud counter: 16-bit, restarts at 0 on every state entry; "mid" = CLKS_PER_BIT/2.
//  Bit value: majority of rx_s at mid-1, mid, mid+1.
//  States:
//   IDLE   : wait for rx_s 1->0 with Rx_En_Sig=1 -> START; Busy=1.
//            Edge arming requires rx_s high for >=1 cycle (break/low line never re-triggers).
//   START  : at mid+1, voted bit=1 -> IDLE (false start, no Done, no error);
//            else realign to bit boundary -> DATA.
//   DATA   : DATA_BITS bits, each sampled per vote; shift into rx_shift LSB first.
//            After last bit -> PARITY if PARITY!=0, else STOP.
//   PARITY : sample; par_err = (XOR(data)^bit) != (PARITY==1 ? 1 : 0) -> STOP.
//   STOP   : STOP_BITS bits sampled; any low sample sets frm_err.
//            After the last stop bit's vote (mid+1) -> DONE. Do not wait out the bit.
//   DONE   : one cycle. Rx_Data<=rx_shift, Parity_Err<=par_err, Frame_Err<=frm_err,
//            Rx_Done_Sig=1 -> IDLE.
//  Latency: Rx_Done_Sig rises 2 cycles after the mid+1 sample of the last stop bit.
//  Errors do not suppress Done; data is delivered with flags and the consumer decides.
//  Rx_Data, Parity_Err and Frame_Err change only in DONE; stable between Done pulses.
//  Rx_En_Sig low in any non-IDLE state: next cycle -> IDLE, Busy=0, no Done.
//   Outputs keep their previous values.
//  Back-to-back frames: a new start edge is accepted in the first IDLE cycle after DONE.
//  Counter wrap: counter never exceeds CLKS_PER_BIT-1; the bit index saturates at DATA_BITS-1.
//  Reset mid-frame: immediate IDLE; outputs cleared as at reset.
// TESTING (CLKS_PER_BIT=16 unless stated)
//  8N1, send 0xA5 -> one Done pulse; Rx_Data=0xA5; Parity_Err=0; Frame_Err=0.
//   Done occurs within 2 cycles after stop-bit mid+1.
//  8E1: send 0x03 with parity=1 -> Parity_Err=1, Rx_Data=0x03.
//   Same word with parity=0 -> Parity_Err=0.
//  8N1, send 0x55 with stop bit driven low -> Done, Rx_Data=0x55, Frame_Err=1.
//   Line then held low 40 cycles -> no further Done; then high + valid 0x12 -> 0x12.
//  Glitch: line low for 5 cycles then high -> no Done; Busy back to 0 by cycle 10.
//   Next frame 0x7E received correctly.
//  Noise: one-cycle inversion exactly at mid of data bit 3 of 0x00 -> majority gives 0x00.
//  Rx_En_Sig dropped during data bit 4 of 0xFF -> no Done; Rx_Data keeps old value.
//   Re-enable; 0x81 then received correctly.
//  DATA_BITS=9, PARITY=1, STOP_BITS=2: 0x1A5 back-to-back x4 -> 4 Done pulses, no errors.

Source files
------------

// File: rtl/uart_rx_param.sv
// ============================================================================
// uart_rx_param
// ----------------------------------------------------------------------------
// Parametrised UART receiver. It combines the input synchroniser, the start
// edge detector and the baud counter in one block. Each bit is decided by a
// 3-sample majority vote around the bit centre. Parity and framing errors are
// reported alongside the received word; they do not suppress delivery, so the
// consumer decides what to do with a flagged frame.
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per serial bit (8..65535)
//   DATA_BITS    : data bits per frame (5..9), LSB first on the line
//   PARITY       : 0 = none, 1 = odd, 2 = even
//   STOP_BITS    : 1 or 2
//
// Ports
//   CLK          in   system clock
//   RST_n        in   asynchronous, active-low reset
//   Rx_Pin_In    in   raw serial line, idle high, asynchronous to CLK
//   Rx_En_Sig    in   receive enable; low ignores the line / aborts a frame
//   Rx_Data      out  last received word, held until the next Done
//   Rx_Done_Sig  out  one-cycle pulse: Rx_Data and error flags are valid
//   Parity_Err   out  parity mismatch on the last frame (always 0 if PARITY=0)
//   Frame_Err    out  a stop-bit vote was low on the last frame
//   Busy         out  high from start-edge detect until return to IDLE
// ============================================================================
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 Rx_Pin_In,
    input  logic                 Rx_En_Sig,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Done_Sig,
    output logic                 Parity_Err,
    output logic                 Frame_Err,
    output logic                 Busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [15:0] LP_CNT_LAST  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_CNT_MID   = 16'(CLKS_PER_BIT / 2);
    localparam logic [15:0] LP_CNT_MID_M = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] LP_CNT_MID_P = 16'(CLKS_PER_BIT / 2 + 1);
    // START begins one cycle into the start bit (edge detect latency), so it
    // ends one count early to put DATA count 0 on the first data-bit boundary.
    localparam logic [15:0] LP_CNT_START_END = 16'(CLKS_PER_BIT - 2);

    localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LP_IDX_ONE  = IDX_W'(1);
    localparam logic             LP_LAST_STOP = 1'(STOP_BITS - 1);
    // Required XOR over data and parity bit: 1 for odd parity, 0 for even.
    localparam logic             LP_PAR_TARGET = (PARITY == 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam logic [2:0] LP_AFTER_DATA = (PARITY != 0) ? ST_PARITY : ST_STOP;

    // ------------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------------
    logic                 r_sync_meta;
    logic                 r_rx_s;
    logic                 r_rx_s_d;

    logic [2:0]           r_state;
    logic [15:0]          r_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_stop_idx;
    logic                 r_vote_a;
    logic                 r_vote_b;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_frm_err;

    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_done;
    logic                 r_parity_err;
    logic                 r_frame_err;

    logic                 w_fall;
    logic                 w_vote;
    logic                 w_at_vote;
    logic                 w_cnt_last;
    logic                 w_last_bit;
    logic                 w_last_stop;
    logic                 w_abort;
    logic [2:0]           w_state_nxt;
    logic                 w_cnt_clr;

    // ------------------------------------------------------------------------
    // Input synchroniser and falling-edge detect
    // ------------------------------------------------------------------------
    // The flops preset to 1 so reset looks like an idle line and cannot fake
    // a start edge. Because the edge needs r_rx_s_d high, a line that stays
    // low (break) can only trigger once it has been seen high again.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync_meta <= 1'b1;
            r_rx_s      <= 1'b1;
            r_rx_s_d    <= 1'b1;
        end else begin
            // NOTE: sequential state uses <= so every flop samples the
            // pre-edge value of its source; blocking here would collapse
            // the synchroniser chain into a single stage.
            r_sync_meta <= Rx_Pin_In;
            r_rx_s      <= r_sync_meta;
            r_rx_s_d    <= r_rx_s;
        end
    end

    assign w_fall = r_rx_s_d & ~r_rx_s;

    // ------------------------------------------------------------------------
    // Bit-timing decodes and majority vote
    // ------------------------------------------------------------------------
    assign w_at_vote   = (r_cnt == LP_CNT_MID_P);
    assign w_cnt_last  = (r_cnt == LP_CNT_LAST);
    assign w_last_bit  = (r_bit_idx == LP_LAST_IDX);
    assign w_last_stop = (r_stop_idx == LP_LAST_STOP);
    assign w_abort     = (r_state != ST_IDLE) && !Rx_En_Sig;

    // Samples at mid-1 and mid are held; the third is the live value at mid+1.
    assign w_vote = (r_vote_a & r_vote_b) | (r_vote_a & r_rx_s) | (r_vote_b & r_rx_s);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_vote_a <= 1'b1;
            r_vote_b <= 1'b1;
        end else begin
            if (r_cnt == LP_CNT_MID_M) r_vote_a <= r_rx_s;
            if (r_cnt == LP_CNT_MID)   r_vote_b <= r_rx_s;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter-restart decode
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no
        // latch is inferred.
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        if (w_abort) begin
            w_state_nxt = ST_IDLE;
            w_cnt_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cnt_clr = 1'b1;
                    if (Rx_En_Sig && w_fall) w_state_nxt = ST_START;
                end
                ST_START: begin
                    if (w_at_vote && w_vote) begin
                        // Start bit voted high: a glitch, not a frame.
                        w_state_nxt = ST_IDLE;
                        w_cnt_clr   = 1'b1;
                    end else if (r_cnt == LP_CNT_START_END) begin
                        w_state_nxt = ST_DATA;
                        w_cnt_clr   = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_cnt_last) begin
                        w_cnt_clr = 1'b1;
                        if (w_last_bit) w_state_nxt = LP_AFTER_DATA;
                    end
                end
                ST_PARITY: begin
                    if (w_cnt_last) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_STOP;
                    end
                end
                ST_STOP: begin
                    // The last stop bit is finished at its vote so the next
                    // start edge can be caught without waiting out the bit.
                    if (w_at_vote && w_last_stop) begin
                        w_state_nxt = ST_DONE;
                        w_cnt_clr   = 1'b1;
                    end else if (w_cnt_last) begin
                        w_cnt_clr = 1'b1;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_clr   = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State register and baud counter
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cnt_clr) r_cnt <= 16'd0;
            else           r_cnt <= r_cnt + 16'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Bit and stop-bit indices
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
        end else begin
            if (r_state == ST_DATA && w_cnt_last && !w_last_bit)
                r_bit_idx <= r_bit_idx + LP_IDX_ONE;
            if (r_state == ST_STOP && w_cnt_last && !w_last_stop)
                r_stop_idx <= r_stop_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Data shift register and per-frame error accumulation
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_shift   <= '0;
            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
        end else begin
            // LSB arrives first, so shifting in from the top leaves it at bit 0.
            if (r_state == ST_DATA && w_at_vote)
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};

            if (r_state == ST_IDLE) begin
                r_par_err <= 1'b0;
                r_frm_err <= 1'b0;
            end else begin
                if (r_state == ST_PARITY && w_at_vote)
                    r_par_err <= ((^r_shift) ^ w_vote) != LP_PAR_TARGET;
                if (r_state == ST_STOP && w_at_vote && !w_vote)
                    r_frm_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: updated only on delivery, held otherwise
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_rx_data    <= '0;
            r_done       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_DONE && !w_abort) begin
                r_rx_data    <= r_shift;
                r_parity_err <= r_par_err;
                r_frame_err  <= r_frm_err;
                r_done       <= 1'b1;
            end
        end
    end

    assign Rx_Data     = r_rx_data;
    assign Rx_Done_Sig = r_done;
    assign Parity_Err  = r_parity_err;
    assign Frame_Err   = r_frame_err;
    assign Busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// ============================================================================
// tb_uart_rx_param
// ----------------------------------------------------------------------------
// Directed bench for uart_rx_param at 16 clocks per bit. Three instances run
// side by side: 8N1 (index 0), 8E1 (index 1) and 9O2 (index 2), each with its
// own serial line and enable. Lines are driven 1 ns after a rising edge and
// outputs are read at the same offset or on the falling edge.
// ============================================================================
module tb_uart_rx_param;

    localparam int CLKS = 16;
    // Rising edges from driving the last stop bit until Done is visible:
    // 2 synchroniser stages + vote at count mid+1 (9) + DONE state + output reg.
    localparam int DONE_LAT = 13;

    logic       clk;
    logic       rst_n;
    logic [2:0] line;
    logic [2:0] en;

    logic [7:0] data0, data1;
    logic [8:0] data2;
    logic       done0, done1, done2;
    logic       pe0, pe1, pe2;
    logic       fe0, fe1, fe2;
    logic       busy0, busy1, busy2;

    int errors = 0;
    int checks = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;

    uart_rx_param #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .CLK(clk), .RST_n(rst_n), .Rx_Pin_In(line[0]), .Rx_En_Sig(en[0]),
        .Rx_Data(data0), .Rx_Done_Sig(done0), .Parity_Err(pe0), .Frame_Err(fe0), .Busy(busy0)
    );

    uart_rx_param #(.CLKS_PER_BIT(CLKS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .CLK(clk), .RST_n(rst_n), .Rx_Pin_In(line[1]), .Rx_En_Sig(en[1]),
        .Rx_Data(data1), .Rx_Done_Sig(done1), .Parity_Err(pe1), .Frame_Err(fe1), .Busy(busy1)
    );

    uart_rx_param #(.CLKS_PER_BIT(CLKS), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u_9o2 (
        .CLK(clk), .RST_n(rst_n), .Rx_Pin_In(line[2]), .Rx_En_Sig(en[2]),
        .Rx_Data(data2), .Rx_Done_Sig(done2), .Parity_Err(pe2), .Frame_Err(fe2), .Busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done0) done_cnt0++;
    always @(negedge clk) if (done1) done_cnt1++;
    always @(negedge clk) if (done2) done_cnt2++;

    // ------------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic get_done(input int d);
        case (d)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    // Sends one frame on line d. ev_kind 1 inverts the line for one cycle at
    // the centre of data bit ev_bit; ev_kind 2 drops the enable there.
    // done_at is the edge count into the last stop bit where Done was seen.
    task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                              input bit has_par, input logic pbit,
                              input int nstop, input logic stop_v,
                              input int ev_bit, input int ev_kind,
                              output int done_at);
        done_at = 0;
        line[d] = 1'b0;
        tick(CLKS);
        for (int i = 0; i < nbits; i++) begin
            line[d] = data[i];
            if (i == ev_bit && ev_kind == 1) begin
                tick(CLKS / 2);
                line[d] = ~data[i];
                tick(1);
                line[d] = data[i];
                tick(CLKS / 2 - 1);
            end else if (i == ev_bit && ev_kind == 2) begin
                tick(CLKS / 2);
                en[d] = 1'b0;
                tick(CLKS / 2);
            end else begin
                tick(CLKS);
            end
        end
        if (has_par) begin
            line[d] = pbit;
            tick(CLKS);
        end
        for (int s = 0; s < nstop; s++) begin
            line[d] = stop_v;
            if (s == nstop - 1) begin
                for (int c = 1; c <= CLKS; c++) begin
                    tick(1);
                    if (get_done(d) && done_at == 0) done_at = c;
                end
            end else begin
                tick(CLKS);
            end
        end
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        checks++;
        if ({data0, done0, pe0, fe0, busy0} !== 12'h000) begin
            errors++;
            $display("FAIL reset_8n1: got %h expected 000", {data0, done0, pe0, fe0, busy0});
        end
        checks++;
        if ({data1, done1, pe1, fe1, busy1} !== 12'h000) begin
            errors++;
            $display("FAIL reset_8e1: got %h expected 000", {data1, done1, pe1, fe1, busy1});
        end
        checks++;
        if ({data2, done2, pe2, fe2, busy2} !== 13'h0000) begin
            errors++;
            $display("FAIL reset_9o2: got %h expected 0000", {data2, done2, pe2, fe2, busy2});
        end
        rst_n = 1'b1;
        tick(4);
    endtask

    task automatic test_8n1_basic;
        int dc;
        int at;
        dc = done_cnt0;
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0, at);
        tick(4);
        checks++;
        if (done_cnt0 - dc !== 1) begin
            errors++;
            $display("FAIL a5_done_count: got %0d expected 1", done_cnt0 - dc);
        end
        checks++;
        if (at !== DONE_LAT) begin
            errors++;
            $display("FAIL a5_done_latency: got %0d expected %0d", at, DONE_LAT);
        end
        checks++;
        if (data0 !== 8'hA5) begin
            errors++;
            $display("FAIL a5_data: got %h expected a5", data0);
        end
        checks++;
        if ({pe0, fe0} !== 2'b00) begin
            errors++;
            $display("FAIL a5_flags: got %b expected 00", {pe0, fe0});
        end
    endtask

    task automatic test_noise;
        int at;
        send_frame(0, 9'h000, 8, 1'b0, 1'b0, 1, 1'b1, 3, 1, at);
        tick(4);
        checks++;
        if (at !== DONE_LAT) begin
            errors++;
            $display("FAIL noise_done: got %0d expected %0d", at, DONE_LAT);
        end
        checks++;
        if (data0 !== 8'h00) begin
            errors++;
            $display("FAIL noise_data: got %h expected 00", data0);
        end
    endtask

    task automatic test_frame_err;
        int dc;
        int at;
        send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b0, -1, 0, at);
        checks++;
        if (at !== DONE_LAT) begin
            errors++;
            $display("FAIL ferr_done: got %0d expected %0d", at, DONE_LAT);
        end
        checks++;
        if (data0 !== 8'h55) begin
            errors++;
            $display("FAIL ferr_data: got %h expected 55", data0);
        end
        checks++;
        if (fe0 !== 1'b1) begin
            errors++;
            $display("FAIL ferr_flag: got %b expected 1", fe0);
        end
        dc = done_cnt0;
        tick(40);
        checks++;
        if (done_cnt0 - dc !== 0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL break_no_retrigger: done %0d busy %b expected 0 0", done_cnt0 - dc, busy0);
        end
        line[0] = 1'b1;
        tick(8);
        send_frame(0, 9'h012, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0, at);
        tick(4);
        checks++;
        if (data0 !== 8'h12) begin
            errors++;
            $display("FAIL after_break_data: got %h expected 12", data0);
        end
        checks++;
        if (fe0 !== 1'b0) begin
            errors++;
            $display("FAIL after_break_ferr: got %b expected 0", fe0);
        end
    endtask

    task automatic test_glitch;
        int dc;
        int busy_hi;
        int at;
        dc = done_cnt0;
        busy_hi = 0;
        line[0] = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            if (i == 6) line[0] = 1'b1;
            tick(1);
            if (busy0) busy_hi++;
        end
        checks++;
        if (busy_hi < 1 || busy_hi > 10) begin
            errors++;
            $display("FAIL glitch_busy_cycles: got %0d expected 1..10", busy_hi);
        end
        checks++;
        if (done_cnt0 - dc !== 0 || busy0 !== 1'b0) begin
            errors++;
            $display("FAIL glitch_no_done: done %0d busy %b expected 0 0", done_cnt0 - dc, busy0);
        end
        checks++;
        if (data0 !== 8'h12) begin
            errors++;
            $display("FAIL glitch_data_held: got %h expected 12", data0);
        end
        send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0, at);
        tick(4);
        checks++;
        if (at !== DONE_LAT || data0 !== 8'h7E) begin
            errors++;
            $display("FAIL post_glitch_7e: done_at %0d data %h expected %0d 7e", at, data0, DONE_LAT);
        end
    endtask

    task automatic test_enable_abort;
        int dc;
        int at;
        dc = done_cnt0;
        send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1, 4, 2, at);
        tick(8);
        checks++;
        if (at !== 0 || done_cnt0 - dc !== 0) begin
            errors++;
            $display("FAIL abort_no_done: done_at %0d count %0d expected 0 0", at, done_cnt0 - dc);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: got %b expected 0", busy0);
        end
        checks++;
        if (data0 !== 8'h7E) begin
            errors++;
            $display("FAIL abort_data_held: got %h expected 7e", data0);
        end
        en[0] = 1'b1;
        tick(4);
        send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0, at);
        tick(4);
        checks++;
        if (at !== DONE_LAT || data0 !== 8'h81) begin
            errors++;
            $display("FAIL reenable_81: done_at %0d data %h expected %0d 81", at, data0, DONE_LAT);
        end
        checks++;
        if ({pe0, fe0} !== 2'b00) begin
            errors++;
            $display("FAIL reenable_flags: got %b expected 00", {pe0, fe0});
        end
    endtask

    task automatic test_parity;
        int dc;
        int at;
        dc = done_cnt1;
        // 0x03 has two ones; even parity requires parity bit 0, so 1 is an error.
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1, -1, 0, at);
        tick(4);
        checks++;
        if (done_cnt1 - dc !== 1 || data1 !== 8'h03) begin
            errors++;
            $display("FAIL par_bad_frame: count %0d data %h expected 1 03", done_cnt1 - dc, data1);
        end
        checks++;
        if (pe1 !== 1'b1) begin
            errors++;
            $display("FAIL par_bad_flag: got %b expected 1", pe1);
        end
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1, -1, 0, at);
        tick(4);
        checks++;
        if (done_cnt1 - dc !== 2 || data1 !== 8'h03) begin
            errors++;
            $display("FAIL par_good_frame: count %0d data %h expected 2 03", done_cnt1 - dc, data1);
        end
        checks++;
        if ({pe1, fe1} !== 2'b00) begin
            errors++;
            $display("FAIL par_good_flags: got %b expected 00", {pe1, fe1});
        end
    endtask

    task automatic test_back_to_back;
        int dc;
        int at;
        dc = done_cnt2;
        // 0x1A5 holds five ones, so odd parity needs parity bit 0.
        for (int k = 0; k < 4; k++) begin
            send_frame(2, 9'h1A5, 9, 1'b1, 1'b0, 2, 1'b1, -1, 0, at);
            checks++;
            if (at !== DONE_LAT) begin
                errors++;
                $display("FAIL b2b_done_%0d: got %0d expected %0d", k, at, DONE_LAT);
            end
            checks++;
            if (data2 !== 9'h1A5) begin
                errors++;
                $display("FAIL b2b_data_%0d: got %h expected 1a5", k, data2);
            end
            checks++;
            if ({pe2, fe2} !== 2'b00) begin
                errors++;
                $display("FAIL b2b_flags_%0d: got %b expected 00", k, {pe2, fe2});
            end
        end
        tick(4);
        checks++;
        if (done_cnt2 - dc !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", done_cnt2 - dc);
        end
    endtask

    task automatic test_reset_midframe;
        line[0] = 1'b0;
        tick(CLKS);
        line[0] = 1'b1;
        tick(CLKS);
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy: got %b expected 1", busy0);
        end
        rst_n = 1'b0;
        #2;
        checks++;
        if ({data0, done0, pe0, fe0, busy0} !== 12'h000) begin
            errors++;
            $display("FAIL midframe_reset: got %h expected 000", {data0, done0, pe0, fe0, busy0});
        end
        tick(2);
        rst_n = 1'b1;
        tick(4);
    endtask

    // ------------------------------------------------------------------------
    // Sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_n = 1'b1;
        line  = 3'b111;
        en    = 3'b111;
        #2;
        test_reset;
        test_8n1_basic;
        test_noise;
        test_frame_err;
        test_glitch;
        test_enable_abort;
        test_parity;
        test_back_to_back;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
